// File: rtl/sc_stage_scheduler_if.sv
// sc_stage_scheduler_if: handshake bundle between the SC stage scheduler and its consumer.
//   start       consumer -> scheduler  one-cycle decode request
//   hold        consumer -> scheduler  downstream stall
//   en          scheduler -> consumer  op issue strobe
//   stage_index scheduler -> consumer  tree stage of the issued op
//   exe_index   scheduler -> consumer  sub-cycle of the issued op within its stage
//   op_g        scheduler -> consumer  0 = f op, 1 = g op
//   leaf_valid  scheduler -> consumer  stage-0 LLR of bit_index ready
//   bit_index   scheduler -> consumer  bit currently being decoded
//   busy        scheduler -> consumer  decode in progress
//   done        scheduler -> consumer  last leaf issued
interface sc_stage_scheduler_if #(
    parameter int n = 3,
    parameter int p = 1
);
    logic                 start;
    logic                 hold;
    logic                 en;
    logic [$clog2(n)-1:0] stage_index;
    logic [n-p-1:0]       exe_index;
    logic                 op_g;
    logic                 leaf_valid;
    logic [n-1:0]         bit_index;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, hold,
        output en, stage_index, exe_index, op_g, leaf_valid, bit_index, busy, done
    );

    modport slave (
        output start, hold,
        input  en, stage_index, exe_index, op_g, leaf_valid, bit_index, busy, done
    );
endinterface

// File: rtl/sc_stage_scheduler.sv
// sc_stage_scheduler: issues the f/g op schedule of a successive-cancellation polar decoder.
//   clk  clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  sc_stage_scheduler_if master: start/hold in; en, stage_index, exe_index,
//        op_g, leaf_valid, bit_index, busy, done out (all registered)
module sc_stage_scheduler #(
    parameter int n   = 3,
    parameter int p   = 1,
    parameter int GAP = 1
) (
    input logic                  clk,
    input logic                  rst,
    sc_stage_scheduler_if.master bus
);
    localparam int SW = $clog2(n);
    localparam int EW = n - p;

    typedef enum logic [2:0] {IDLE, OP, BUBBLE, LEAF, DONE} state_t;

    state_t        state, ns;
    logic [SW-1:0] stg, nstg, tz;
    logic [EW-1:0] exe, nexe;
    logic          g, ng;
    logic [n-1:0]  bi, nbi, bi_inc;
    logic [2:0]    bub, nbub;
    logic          frz, grp_last, to_next;

    logic          en_q, g_q, leaf_q, busy_q, done_q;
    logic [SW-1:0] stg_q;
    logic [EW-1:0] exe_q;
    logic          en_d, g_d, leaf_d, busy_d, done_d;
    logic [SW-1:0] stg_d;
    logic [EW-1:0] exe_d;

    // A frozen cycle keeps every counter where it is; the item shown before the
    // freeze is the one whose successor is issued once hold drops.
    assign frz = bus.hold && (state == OP || state == BUBBLE || state == LEAF);

    // Group length is 2^(s-p) for s >= p, otherwise a single cycle.
    assign grp_last = int'(exe) == ((int'(stg) >= p) ? (1 << (int'(stg) - p)) - 1 : 0);

    // End of a group's trailing bubbles (or of the group itself when GAP is 0).
    assign to_next = (state == OP && grp_last && GAP == 0) ||
                     (state == BUBBLE && int'(bub) == GAP - 1);

    assign bi_inc = bi + 1'b1;

    // First stage of the next bit is its trailing-zero count; lowest set bit wins.
    always_comb begin
        tz = '0;
        for (int i = n - 1; i >= 0; i--)
            if (bi_inc[i]) tz = SW'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            stg    <= '0;
            exe    <= '0;
            g      <= 1'b0;
            bi     <= '0;
            bub    <= '0;
            en_q   <= 1'b0;
            stg_q  <= '0;
            exe_q  <= '0;
            g_q    <= 1'b0;
            leaf_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= ns;
            stg    <= nstg;
            exe    <= nexe;
            g      <= ng;
            bi     <= nbi;
            bub    <= nbub;
            en_q   <= en_d;
            stg_q  <= stg_d;
            exe_q  <= exe_d;
            g_q    <= g_d;
            leaf_q <= leaf_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        ns   = state;
        nstg = stg;
        nexe = exe;
        ng   = g;
        nbi  = bi;
        nbub = bub;
        if (!frz) begin
            if (to_next) begin
                ns   = (stg == '0) ? LEAF : OP;
                nstg = (stg == '0) ? stg : stg - 1'b1;
                nexe = '0;
                ng   = 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        ns   = OP;
                        nstg = SW'(n - 1);
                        nexe = '0;
                        ng   = 1'b0;
                        nbi  = '0;
                    end
                    OP: if (grp_last) begin
                        ns   = BUBBLE;
                        nbub = '0;
                    end else begin
                        nexe = exe + 1'b1;
                    end
                    BUBBLE: nbub = bub + 1'b1;
                    LEAF: if (&bi) begin
                        ns = DONE;
                    end else begin
                        ns   = OP;
                        nbi  = bi_inc;
                        nstg = tz;
                        nexe = '0;
                        ng   = 1'b1;
                    end
                    DONE: begin
                        ns  = IDLE;
                        nbi = '0;
                    end
                    default: ns = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        en_d   = !frz && ns == OP;
        stg_d  = frz ? stg_q : (ns == OP ? nstg : '0);
        exe_d  = frz ? exe_q : (ns == OP ? nexe : '0);
        g_d    = frz ? g_q : (ns == OP && ng);
        leaf_d = !frz && ns == LEAF;
        busy_d = ns != IDLE;
        done_d = ns == DONE;
    end

    assign bus.en          = en_q;
    assign bus.stage_index = stg_q;
    assign bus.exe_index   = exe_q;
    assign bus.op_g        = g_q;
    assign bus.leaf_valid  = leaf_q;
    assign bus.bit_index   = bi;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_sc_stage_scheduler.sv
// tb_sc_stage_scheduler: directed bench for sc_stage_scheduler with n=3, p=1, GAP=1.
module tb_sc_stage_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sc_stage_scheduler_if #(.n(3), .p(1)) bus ();
    sc_stage_scheduler #(.n(3), .p(1), .GAP(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic       en;
        logic [1:0] stg;
        logic [1:0] exe;
        logic       g;
        logic       leaf;
        logic [2:0] bi;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t exp_q[$];
    vec_t obs;
    int   checks   = 0;
    int   failures = 0;
    int   bc;

    assign obs = {bus.en, bus.stage_index, bus.exe_index, bus.op_g, bus.leaf_valid,
                  bus.bit_index, bus.busy, bus.done};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int s, input int e, input int gg, input int b);
        vec_t v;
        v = '0; v.en = 1'b1; v.stg = 2'(s); v.exe = 2'(e); v.g = 1'(gg); v.bi = 3'(b); v.busy = 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic bub(input int b);
        vec_t v;
        v = '0; v.bi = 3'(b); v.busy = 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic lf(input int b);
        vec_t v;
        v = '0; v.leaf = 1'b1; v.bi = 3'(b); v.busy = 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic dn;
        vec_t v;
        v = '0; v.bi = 3'd7; v.busy = 1'b1; v.done = 1'b1;
        exp_q.push_back(v);
    endtask

    // Hand-derived cycle table for one full decode, starting the cycle after start.
    task automatic build_table;
        op(2,0,0,0); op(2,1,0,0); bub(0); op(1,0,0,0); bub(0); op(0,0,0,0); bub(0); lf(0);
        op(0,0,1,1); bub(1); lf(1);
        op(1,0,1,2); bub(2); op(0,0,0,2); bub(2); lf(2);
        op(0,0,1,3); bub(3); lf(3);
        op(2,0,1,4); op(2,1,1,4); bub(4); op(1,0,0,4); bub(4); op(0,0,0,4); bub(4); lf(4);
        op(0,0,1,5); bub(5); lf(5);
        op(1,0,1,6); bub(6); op(0,0,0,6); bub(6); lf(6);
        op(0,0,1,7); bub(7); lf(7);
        dn();
    endtask

    // Runs one decode from IDLE. hk/hk2: table index after which hold is raised for
    // hn/hn2 cycles; hd: hold during DONE; sk: start pulse while busy; rk: rst asserted.
    task automatic drive_decode(input int hk, input int hn, input int hk2, input int hn2,
                                input bit hd, input int sk, input int rk, output int busy_cycles);
        int   leaves, dones, h;
        vec_t fz;
        busy_cycles = 0; leaves = 0; dones = 0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs !== exp_q[k]) begin
                failures++;
                $display("FAIL seq[%0d]: got %b expected %b", k, obs, exp_q[k]);
            end
            busy_cycles += int'(obs.busy);
            leaves      += int'(obs.leaf);
            dones       += int'(obs.done);
            if (k == rk) begin
                #1 rst = 1'b1;
                #1;
                checks++;
                if (obs !== '0) begin
                    failures++;
                    $display("FAIL rst_async: got %b expected 0", obs);
                end
                tick;
                rst = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    tick;
                    checks++;
                    if (obs !== '0) begin
                        failures++;
                        $display("FAIL rst_idle[%0d]: got %b expected 0", j, obs);
                    end
                end
                checks++;
                if (dones != 0) begin
                    failures++;
                    $display("FAIL rst_no_done: got %0d done pulses expected 0", dones);
                end
                return;
            end
            if (k == sk) bus.start = 1'b1;
            if (k == hk || k == hk2) begin
                h  = (k == hk) ? hn : hn2;
                fz = exp_q[k];
                fz.en = 1'b0;
                fz.leaf = 1'b0;
                bus.hold = 1'b1;
                for (int j = 0; j < h; j++) begin
                    tick;
                    bus.start = 1'b0;
                    if (j == h - 1) bus.hold = 1'b0;
                    checks++;
                    if (obs !== fz) begin
                        failures++;
                        $display("FAIL hold[%0d+%0d]: got %b expected %b", k, j, obs, fz);
                    end
                    busy_cycles += int'(obs.busy);
                end
            end
            if (k == exp_q.size() - 1 && hd) bus.hold = 1'b1;
            tick;
            bus.start = 1'b0;
        end
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL idle_after: got %b expected 0", obs);
        end
        bus.hold = 1'b0;
        checks++;
        if (leaves != 8) begin
            failures++;
            $display("FAIL leaf_count: got %0d expected 8", leaves);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL done_count: got %0d expected 1", dones);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b0; bus.hold = 1'b0;
        repeat (3) tick;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_state: got %b expected 0", obs);
        end
        rst = 1'b0;
        repeat (2) tick;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_release: got %b expected 0", obs);
        end
    endtask

    task automatic test_hold_idle;
        bus.hold = 1'b1;
        repeat (2) tick;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL hold_idle: got %b expected 0", obs);
        end
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.hold = 1'b0;
        checks++;
        if (obs !== exp_q[0]) begin
            failures++;
            $display("FAIL hold_idle_start: got %b expected %b", obs, exp_q[0]);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_full_decode;
        drive_decode(-1, 0, -1, 0, 1'b0, -1, -1, bc);
        checks++;
        if (bc != 39) begin
            failures++;
            $display("FAIL full_busy_len: got %0d expected 39", bc);
        end
    endtask

    task automatic test_back_to_back;
        drive_decode(-1, 0, -1, 0, 1'b0, -1, -1, bc);
        checks++;
        if (bc != 39) begin
            failures++;
            $display("FAIL b2b_busy_len: got %0d expected 39", bc);
        end
    endtask

    task automatic test_hold;
        drive_decode(0, 3, -1, 0, 1'b0, -1, -1, bc);
        checks++;
        if (bc != 42) begin
            failures++;
            $display("FAIL hold_busy_len: got %0d expected 42", bc);
        end
        drive_decode(2, 2, 7, 1, 1'b1, -1, -1, bc);
        checks++;
        if (bc != 42) begin
            failures++;
            $display("FAIL hold_bub_leaf_len: got %0d expected 42", bc);
        end
    endtask

    task automatic test_start_busy;
        drive_decode(-1, 0, -1, 0, 1'b0, 17, -1, bc);
        checks++;
        if (bc != 39) begin
            failures++;
            $display("FAIL start_busy_len: got %0d expected 39", bc);
        end
    endtask

    task automatic test_reset_mid;
        drive_decode(-1, 0, -1, 0, 1'b0, -1, 28, bc);
        drive_decode(-1, 0, -1, 0, 1'b0, -1, -1, bc);
        checks++;
        if (bc != 39) begin
            failures++;
            $display("FAIL restart_busy_len: got %0d expected 39", bc);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        build_table();
        test_reset();
        test_full_decode();
        test_back_to_back();
        test_hold();
        test_hold_idle();
        test_start_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sc_stage_scheduler.md
SC_STAGE_SCHEDULER -- requirements
Module: sc_stage_scheduler

Interface
REQ-001 Parameter n, default 3: log2 of code length N = 2^n; n >= 2 SHALL hold.
REQ-002 Parameter p, default 1: log2 of processing-element count P = 2^p; 0 <= p < n SHALL hold.
REQ-003 Parameter GAP, default 1: number of bubble cycles after each op group (0..7).
REQ-004 clk  in  1  the single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  one-cycle decode request; honoured only in IDLE.
REQ-007 hold  in  1  stall from downstream; freezes scheduling while high.
REQ-008 en  out  1  op issue strobe, feeds the read-port controller en.
REQ-009 stage_index  out  $clog2(n)  tree stage of the issued op.
REQ-010 exe_index  out  n-p  sub-cycle of the issued op within its stage.
REQ-011 op_g  out  1  0 = f op, 1 = g op; valid when en=1.
REQ-012 leaf_valid  out  1  one-cycle strobe: stage-0 LLR for bit_index is ready for decision and partial-sum update.
REQ-013 bit_index  out  n  index of the bit currently being decoded.
REQ-014 busy  out  1  high from the cycle after start acceptance through the DONE cycle.
REQ-015 done  out  1  one-cycle pulse when the last bit's leaf has been issued.

Function
REQ-016 All outputs SHALL be registered; the FSM states are IDLE, OP, BUBBLE, LEAF and DONE.
REQ-017 Op group length: E(s) = 2^(s-p) cycles if s >= p, else 1 cycle; exe_index SHALL run 0..E(s)-1, one value per issuing cycle.
REQ-018 Bit 0: op groups SHALL be f at stages n-1, n-2, ..., 0.
REQ-019 Bit i > 0: with t = trailing-zero count of i, the first group SHALL be g at stage t, followed by f at stages t-1 down to 0.
REQ-020 After every op group, GAP BUBBLE cycles SHALL follow with en=0; the next group, or LEAF after stage 0, SHALL then follow.
REQ-021 LEAF SHALL last exactly 1 cycle with leaf_valid=1 and en=0; the next bit's first group SHALL begin the following cycle; bit_index SHALL increment on leaving LEAF.
REQ-022 LEAF of bit 2^n-1 SHALL go to DONE (done=1, busy=1, 1 cycle), then to IDLE with bit_index cleared to 0.
REQ-023 start accepted in IDLE: the next cycle SHALL issue en=1, stage_index=n-1, exe_index=0, op_g=0, bit_index=0.
REQ-024 start while busy SHALL be ignored, with no effect on the sequence.
REQ-025 hold sampled high in OP, BUBBLE or LEAF: the next cycle SHALL show en=0 and leaf_valid=0, with stage_index, exe_index, op_g and bit_index unchanged; no counter or bubble count SHALL advance.
REQ-026 The op, bubble or leaf pending when hold rose SHALL resume the cycle after hold is sampled low, with none skipped or repeated.
REQ-027 hold SHALL have no effect in IDLE or DONE.
REQ-028 In IDLE, en, op_g, leaf_valid, busy and done SHALL be 0, and stage_index and exe_index SHALL be 0.
REQ-029 When en=0 outside hold, stage_index and exe_index SHALL be 0.

Reset
REQ-030 rst high SHALL asynchronously force IDLE and set every output and internal counter to 0.
REQ-031 rst asserted mid-decode SHALL abandon the decode, with no done pulse.
REQ-032 The first start after rst deassertion SHALL begin at bit 0.

Verification (n=3, p=1, GAP=1)
REQ-033 Assert rst at any time -> all outputs 0 within the same cycle; busy stays 0 until start.
REQ-034 start pulse -> per cycle (en,stage,exe,op_g): (1,2,0,0), (1,2,1,0), (0,0,0,0), (1,1,0,0), (0,0,0,0), (1,0,0,0), (0,0,0,0), then leaf_valid=1 with bit_index=0.
REQ-035 Continuing: bit 1 -> (1,0,0,1), bubble, leaf; bit 2 -> g at stage 1, bubble, f at stage 0, bubble, leaf; bit 4 -> g at stage 2 with exe 0 then 1.
REQ-036 Full decode -> exactly 8 leaf_valid pulses with bit_index 0..7 in order, one done pulse, busy drops after done; a second start repeats the sequence identically.
REQ-037 hold high for 3 cycles after (1,2,0,0) -> 3 cycles with en=0 and stage=2 held, then (1,2,1,0); total decode length grows by exactly 3 cycles.
REQ-038 start during bit 3 -> ignored; rst during bit 5, then start -> sequence restarts at bit 0 with no done pulse before it.
